// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters (round-robin), registered operands and response.
// Latency: grant edge to resp_valid high is 2 edges; peak throughput one op per 2 cycles.
// Backpressure: resp_ready=0 holds the response stable and blocks every new grant.
module alu_share_arbiter #(
  parameter int DATA_W    = 32,
  parameter int OP_W      = 4,
  parameter int SH_W      = 5,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [OP_W-1:0]   r0_op,
  input  logic [SH_W-1:0]   r0_shamt,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [OP_W-1:0]   r1_op,
  input  logic [SH_W-1:0]   r1_shamt,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [SH_W-1:0]   alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_fZero,
  input  logic              alu_fSign,
  input  logic              alu_fCarry,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_sign,
  output logic              resp_carry,
  output logic              resp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              rr_ptr;
  logic              can_grant;
  logic              gnt_vld;
  logic              gnt_id;
  logic              op_legal_q;

  logic [DATA_W-1:0] opr_a;
  logic [DATA_W-1:0] opr_b;
  logic [OP_W-1:0]   opr_op;
  logic [SH_W-1:0]   opr_shamt;
  logic              opr_id;

  // Opcode set the ALU actually implements; anything else is reported as an error.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_W'(0), OP_W'(1), OP_W'(2), OP_W'(3), OP_W'(4), OP_W'(5),
      OP_W'(8), OP_W'(10), OP_W'(11), OP_W'(12), OP_W'(14), OP_W'(15): op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

  // The ALU only ever sees the registered operands.
  assign alu_a      = opr_a;
  assign alu_b      = opr_b;
  assign alu_op     = opr_op;
  assign alu_shamt  = opr_shamt;
  assign busy       = (state != IDLE);
  assign op_legal_q = op_legal(opr_op);

  // Grant decision and next state; a grant frees the slot in the same cycle the response drains.
  always_comb begin
    state_nxt = state;
    can_grant = 1'b0;
    gnt_vld   = 1'b0;
    gnt_id    = 1'b0;
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    can_grant = !rst && ((state == IDLE) || ((state == RESP) && resp_ready));
    gnt_vld   = can_grant && (r0_valid || r1_valid);
    gnt_id    = (r0_valid && r1_valid) ? rr_ptr : r1_valid;
    r0_ready  = gnt_vld && !gnt_id;
    r1_ready  = gnt_vld && gnt_id;
    case (state)
      IDLE:    state_nxt = gnt_vld ? EXEC : IDLE;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = resp_ready ? (gnt_vld ? EXEC : IDLE) : RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and round-robin pointer; the pointer favours the loser of each grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= PRIO_INIT;
    end else begin
      state <= state_nxt;
      if (gnt_vld) rr_ptr <= ~gnt_id;
    end
  end

  // Operand stage: requester inputs are sampled only on their own grant edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opr_a     <= '0;
      opr_b     <= '0;
      opr_op    <= '0;
      opr_shamt <= '0;
      opr_id    <= 1'b0;
    end else if (gnt_vld) begin
      opr_a     <= gnt_id ? r1_a     : r0_a;
      opr_b     <= gnt_id ? r1_b     : r0_b;
      opr_op    <= gnt_id ? r1_op    : r0_op;
      opr_shamt <= gnt_id ? r1_shamt : r0_shamt;
      opr_id    <= gnt_id;
    end
  end

  // Response channel: capture at the end of EXEC, drop valid only when drained with nothing queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_sign   <= 1'b0;
      resp_carry  <= 1'b0;
      resp_err    <= 1'b0;
    end else if (state == EXEC) begin
      resp_valid  <= 1'b1;
      resp_id     <= opr_id;
      resp_result <= op_legal_q ? alu_result : '0;
      resp_zero   <= op_legal_q ? alu_fZero  : 1'b0;
      resp_sign   <= op_legal_q ? alu_fSign  : 1'b0;
      resp_carry  <= op_legal_q ? alu_fCarry : 1'b0;
      resp_err    <= !op_legal_q;
    end else if ((state == RESP) && resp_ready && !gnt_vld) begin
      resp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  sh;
  } req_t;

  typedef struct {
    bit          id;
    logic [31:0] res;
    bit          z;
    bit          s;
    bit          c;
    bit          e;
    int          cyc;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic        r0_valid, r1_valid;
  logic        r0_ready, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0]  r0_op, r1_op;
  logic [4:0]  r0_shamt, r1_shamt;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic        alu_fZero, alu_fSign, alu_fCarry;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_result;
  logic        resp_zero, resp_sign, resp_carry, resp_err, busy;

  int vectors;
  int miscompares;
  int cyc;
  rsp_t got_q[$];

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_op(r0_op), .r0_shamt(r0_shamt),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_op(r1_op), .r1_shamt(r1_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_fZero(alu_fZero), .alu_fSign(alu_fSign),
    .alu_fCarry(alu_fCarry),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_sign(resp_sign),
    .resp_carry(resp_carry), .resp_err(resp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: {carry, result}. Illegal opcodes deliberately produce nonzero junk.
  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op, input logic [4:0] sh);
    logic [32:0] r;
    case (op)
      4'h0: r = {1'b0, a};
      4'h1: r = {1'b0, a} + {1'b0, b};
      4'h2: r = {1'b0, a & b};
      4'h3: r = {1'b0, a ^ b};
      4'h4: r = {1'b0, a} + {1'b0, ~b} + 33'd1;
      4'h5: r = {1'b0, ~b} + 33'd1;
      4'h8: r = {1'b0, a << b[4:0]};
      4'hA: r = {1'b0, a >> b[4:0]};
      4'hB: r = {1'b0, $unsigned($signed(a) >>> b[4:0])};
      4'hC: r = {1'b0, a << sh};
      4'hE: r = {1'b0, a >> sh};
      4'hF: r = {1'b0, $unsigned($signed(a) >>> sh)};
      default: r = {1'b1, a | 32'h1};
    endcase
    return r;
  endfunction

  always_comb begin
    logic [32:0] t;
    t = alu_f(alu_a, alu_b, alu_op, alu_shamt);
    alu_fCarry = t[32];
    alu_result = t[31:0];
    alu_fZero  = (t[31:0] == 32'd0);
    alu_fSign  = t[31];
  end

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF};
  endfunction

  // What the response for a request must contain.
  function automatic rsp_t exp_rsp(input req_t q);
    rsp_t r;
    logic [32:0] t;
    t = alu_f(q.a, q.b, q.op, q.sh);
    r.id  = q.id;
    r.cyc = 0;
    if (is_legal(q.op)) begin
      r.res = t[31:0]; r.z = (t[31:0] == 0); r.s = t[31]; r.c = t[32]; r.e = 1'b0;
    end else begin
      r.res = 32'd0; r.z = 1'b0; r.s = 1'b0; r.c = 1'b0; r.e = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Behavioural model: one op in flight, one held response, a favoured requester.
  req_t m_ex, m_last, s_req;
  rsp_t m_rsp;
  bit   m_ex_vld, m_rsp_vld, m_prio, e_gv, e_gid, s_rdy;

  task automatic mreset();
    m_ex_vld  = 0;
    m_rsp_vld = 0;
    m_prio    = 1'b0;
    m_last    = '{id: 0, a: 0, b: 0, op: 0, sh: 0};
    m_ex      = m_last;
    m_rsp     = '{id: 0, res: 0, z: 0, s: 0, c: 0, e: 0, cyc: 0};
  endtask

  // Compare process: check every cycle at negedge, advance the model at posedge.
  initial begin : model
    mreset();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) mreset();
      e_gv  = !rst && !m_ex_vld && (!m_rsp_vld || resp_ready) && (r0_valid || r1_valid);
      e_gid = (r0_valid && r1_valid) ? m_prio : r1_valid;
      chk("r0_ready", r0_ready, e_gv && !e_gid);
      chk("r1_ready", r1_ready, e_gv && e_gid);
      chk("busy", busy, m_ex_vld || m_rsp_vld);
      chk("alu_a", alu_a, m_last.a);
      chk("alu_b", alu_b, m_last.b);
      chk("alu_op", alu_op, m_last.op);
      chk("alu_shamt", alu_shamt, m_last.sh);
      chk("resp_valid", resp_valid, m_rsp_vld);
      chk("resp_id", resp_id, m_rsp.id);
      chk("resp_result", resp_result, m_rsp.res);
      chk("resp_flags", {resp_zero, resp_sign, resp_carry, resp_err},
          {m_rsp.z, m_rsp.s, m_rsp.c, m_rsp.e});
      if (!rst && resp_valid && resp_ready && !m_ex_vld)
        got_q.push_back('{id: resp_id, res: resp_result, z: resp_zero, s: resp_sign,
                          c: resp_carry, e: resp_err, cyc: cyc});
      s_rdy = resp_ready;
      s_req = e_gid ? '{id: 1, a: r1_a, b: r1_b, op: r1_op, sh: r1_shamt}
                    : '{id: 0, a: r0_a, b: r0_b, op: r0_op, sh: r0_shamt};
      @(posedge clk);
      if (rst) mreset();
      else if (m_ex_vld) begin
        m_rsp = exp_rsp(m_ex); m_rsp_vld = 1; m_ex_vld = 0;
      end else if (e_gv) begin
        m_ex = s_req; m_last = s_req; m_ex_vld = 1; m_prio = ~s_req.id;
      end else if (m_rsp_vld && s_rdy) m_rsp_vld = 0;
    end
  end

  // Hold valid on the requested ports until each is granted (bounded).
  task automatic serve(input bit want0, input bit want1);
    bit p0, p1, g0, g1;
    p0 = want0; p1 = want1;
    r0_valid = p0; r1_valid = p1;
    for (int i = 0; i < 100 && (p0 || p1); i++) begin
      @(negedge clk);
      g0 = r0_ready; g1 = r1_ready;
      @(posedge clk); #1;
      if (g0) begin p0 = 0; r0_valid = 0; end
      if (g1) begin p1 = 0; r1_valid = 0; end
    end
    chk("serve_timeout", {p0, p1}, 2'b00);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = !busy;
    end
    chk("idle_timeout", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic pop_chk(input string nm, input bit id, input logic [31:0] res,
                         input bit z, input bit s, input bit c, input bit e);
    rsp_t x;
    chk({nm, "_present"}, got_q.size() > 0, 1);
    if (got_q.size() == 0) return;
    x = got_q.pop_front();
    chk({nm, "_id"}, x.id, id);
    chk({nm, "_result"}, x.res, res);
    chk({nm, "_flags"}, {x.z, x.s, x.c, x.e}, {z, s, c, e});
  endtask

  task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [4:0] sh);
    r0_a = a; r0_b = b; r0_op = op; r0_shamt = sh;
  endtask

  task automatic set1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [4:0] sh);
    r1_a = a; r1_b = b; r1_op = op; r1_shamt = sh;
  endtask

  initial begin : stim
    rsp_t x0, x1;
    vectors = 0; miscompares = 0; cyc = 0;
    rst = 1; resp_ready = 1; r0_valid = 1; r1_valid = 0;
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    // Reset state, with a request pending that must not be accepted.
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_r0_ready", r0_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    r0_valid = 0; rst = 0;
    @(posedge clk); #1;

    // Basic add on port 0.
    set0(12, 10, 4'h1, 0);
    serve(1, 0);
    wait_idle();
    pop_chk("t1_add", 0, 22, 0, 0, 0, 0);

    // Illegal opcode on port 1, then a legal op from the same port.
    set1(5, 3, 4'h6, 0);
    serve(0, 1);
    wait_idle();
    pop_chk("t5_err", 1, 0, 0, 0, 0, 1);
    set1(32'h8000_0000, 0, 4'h0, 0);
    serve(0, 1);
    wait_idle();
    pop_chk("t5_fwd", 1, 32'h8000_0000, 0, 1, 0, 0);

    // Simultaneous requests: port 0 first, port 1 back-to-back.
    got_q.delete();
    set0(8, 8, 4'h3, 0); set1(4, 2, 4'h1, 0);
    serve(1, 1);
    wait_idle();
    chk("t2_count", got_q.size(), 2);
    if (got_q.size() == 2) chk("t2_spacing", got_q[1].cyc - got_q[0].cyc, 2);
    pop_chk("t2_r0", 0, 0, 1, 0, 0, 0);
    pop_chk("t2_r1", 1, 6, 0, 0, 0, 0);

    // Both held valid: ids alternate, one op every 2 cycles.
    got_q.delete();
    set0(1, 1, 4'h1, 0); set1(2, 2, 4'h1, 0);
    r0_valid = 1; r1_valid = 1;
    repeat (9) @(posedge clk);
    #1; r0_valid = 0; r1_valid = 0;
    wait_idle();
    chk("t3_count", got_q.size(), 5);
    if (got_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t3_id", got_q[i].id, i % 2);
      for (int i = 1; i < 4; i++) chk("t3_spacing", got_q[i].cyc - got_q[i-1].cyc, 2);
      chk("t3_res0", got_q[0].res, 2);
      chk("t3_res1", got_q[1].res, 4);
    end
    got_q.delete();

    // Consumer stalls 5 cycles: response held, nothing granted, single capture.
    resp_ready = 0;
    set0(32'h0F0F, 32'h00FF, 4'h2, 0);
    serve(1, 0);
    @(posedge clk); #1;
    set0(7, 7, 4'h1, 0); set1(9, 9, 4'h1, 0);
    r0_valid = 1; r1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", resp_valid, 1);
      chk("t4_hold_result", resp_result, 32'h000F);
      chk("t4_r0_ready", r0_ready, 0);
      chk("t4_r1_ready", r1_ready, 0);
      @(posedge clk); #1;
    end
    r0_valid = 0; r1_valid = 0; resp_ready = 1;
    wait_idle();
    chk("t4_count", got_q.size(), 1);
    pop_chk("t4_and", 0, 32'h000F, 0, 0, 0, 0);

    // Reset during EXEC of port-1 sra: no response, back to IDLE.
    set1(32'hFFFF_FFF8, 0, 4'hF, 2);
    serve(0, 1);
    rst = 1;
    @(negedge clk);
    chk("t6_resp_valid", resp_valid, 0);
    chk("t6_busy", busy, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_no_resp", got_q.size(), 0);
    // Port 0 granted (favouring port 1) then reset: favour must return to port 0.
    set0(3, 3, 4'h1, 0);
    serve(1, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    set0(1, 2, 4'h1, 0); set1(5, 6, 4'h1, 0);
    serve(1, 1);
    wait_idle();
    pop_chk("t6_first", 0, 3, 0, 0, 0, 0);
    pop_chk("t6_second", 1, 11, 0, 0, 0, 0);

    // Randomized traffic against the model, including occasional resets.
    for (int i = 0; i < 1500; i++) begin
      r0_valid = $urandom_range(0, 1);
      r1_valid = $urandom_range(0, 1);
      set0($urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
           4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
      set1($urandom, $urandom_range(0, 40), 4'($urandom_range(0, 15)),
           5'($urandom_range(0, 31)));
      resp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
      if (got_q.size() > 0) begin
        x0 = got_q.pop_front();
        x1 = x0;
        chk("rand_err_zero", x1.e ? {x1.res, x1.z, x1.s, x1.c} : 35'd0, 35'd0);
      end
    end
    rst = 0; r0_valid = 0; r1_valid = 0; resp_ready = 1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
